// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage <-> divider handshake bundle.
//   master (EX):      drives signed_div_i, opdata1_i, opdata2_i, start_i, annul_i
//   slave (divider):  drives result_o {hi, lo}, ready_o, busy_o
interface div_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : div_seq_if.slave (operands, start/annul in; result {rem, quo}, ready, busy out)
// Optional feature macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the
// iterations are skipped and the fixup happens on the edge after acceptance.
module div_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus
);

  localparam int unsigned TRIAL_W = DATA_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   divisor;
  logic                neg_quo;
  logic                neg_rem;
  logic [2*DATA_W-1:0] result;
  logic                ready;

  logic [DATA_W-1:0]   abs1_c;
  logic [DATA_W-1:0]   abs2_c;
  logic [TRIAL_W-1:0]  trial_c;
  logic [DATA_W-1:0]   quo_fix_c;
  logic [DATA_W-1:0]   rem_fix_c;

  // Operand magnitudes, next trial subtraction and sign fixup
  always_comb begin
    abs1_c    = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ?
                DATA_W'(DATA_W'(0) - bus.opdata1_i) : bus.opdata1_i;
    abs2_c    = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ?
                DATA_W'(DATA_W'(0) - bus.opdata2_i) : bus.opdata2_i;
    trial_c   = TRIAL_W'({rem, quo[DATA_W-1]}) - TRIAL_W'({1'b0, divisor});
    quo_fix_c = neg_quo ? DATA_W'(DATA_W'(0) - quo) : quo;
    rem_fix_c = neg_rem ? DATA_W'(DATA_W'(0) - rem) : rem;
  end

  // Sequencer and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FREE;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          result <= '0;
          ready  <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            neg_quo <= bus.signed_div_i &
                       (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
            neg_rem <= bus.signed_div_i & bus.opdata1_i[DATA_W-1];
            if (bus.opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state   <= S_ON;
              divisor <= abs2_c;
`ifdef DIV_EARLY_OUT_EN
              // Quotient is trivially zero; go straight to fixup
              if (abs1_c < abs2_c) begin
                quo <= '0;
                rem <= abs1_c;
                cnt <= CNT_LAST;
              end else begin
                quo <= abs1_c;
                rem <= '0;
                cnt <= '0;
              end
`else
              quo <= abs1_c;
              rem <= '0;
              cnt <= '0;
`endif
            end
          end
        end

        S_BYZERO: begin
          result <= '0;
          ready  <= 1'b1;
          state  <= S_END;
        end

        S_ON: begin
          if (bus.annul_i) begin
            result <= '0;
            ready  <= 1'b0;
            state  <= S_FREE;
          end else if (cnt != CNT_LAST) begin
            // quo doubles as the dividend shift register
            if (!trial_c[TRIAL_W-1]) begin
              rem <= trial_c[DATA_W-1:0];
              quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
              rem <= {rem[DATA_W-2:0], quo[DATA_W-1]};
              quo <= {quo[DATA_W-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
          end else begin
            result <= {rem_fix_c, quo_fix_c};
            ready  <= 1'b1;
            state  <= S_END;
          end
        end

        S_END: begin
          if (!bus.start_i || bus.annul_i) begin
            result <= '0;
            ready  <= 1'b0;
            state  <= S_FREE;
          end
        end

        default: begin
          state <= S_FREE;
        end
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.busy_o   = (state == S_BYZERO) || (state == S_ON);

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq. Directed cases plus random
// divisions compared against an arithmetic reference model (64-bit integer
// division), including latency, hold/drop behaviour, annul and async reset.
// Honours DIV_EARLY_OUT_EN for the expected latency.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_seq_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {remainder, quotient} from plain integer arithmetic
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    logic [63:0] q64, r64;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    q64 = 64'(q);
    r64 = 64'(r);
    return {r64[31:0], q64[31:0]};
  endfunction

  // Edges from acceptance (inclusive) until ready is observed
  function automatic int model_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb;
    if (b == 32'd0) return 2;
    la = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    lb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (la < 0) la = -la;
    if (lb < 0) lb = -lb;
`ifdef DIV_EARLY_OUT_EN
    if (la < lb) return 2;
`endif
    return 34;
  endfunction

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit hold_extra);
    logic [63:0] exp_res;
    int exp_lat;
    int n;
    bit done;
    exp_res = model(sgn, a, b);
    exp_lat = model_lat(sgn, a, b);
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        check("busy_after_accept", 64'(bus.busy_o), 64'd1);
        // Operands must be ignored after acceptance
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
      end
      if (bus.ready_o) done = 1'b1;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("result", bus.result_o, exp_res);
    check("busy_in_end", 64'(bus.busy_o), 64'd0);
    if (hold_extra) begin
      @(posedge clk);
      #1;
      check("hold_ready", 64'(bus.ready_o), 64'd1);
      check("hold_result", bus.result_o, exp_res);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("drop_ready", 64'(bus.ready_o), 64'd0);
    check("drop_result", bus.result_o, 64'd0);
  endtask

  initial begin
    bit saw_ready;
    logic sgn;
    logic [31:0] a, b;

    rst = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", bus.result_o, 64'd0);
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases
    run_div(1'b0, 32'd100, 32'd7, 1'b1);
    check("const_100_7", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1);
    run_div(1'b0, 32'h12345678, 32'd0, 1'b1);
    run_div(1'b1, 32'h87654321, 32'd0, 1'b0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_div(1'b0, 32'd3, 32'd10, 1'b0);
    run_div(1'b1, 32'hFFFFFFFD, 32'd10, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);

    // Annul during iteration 10
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_busy", 64'(bus.busy_o), 64'd0);
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) saw_ready = 1'b1;
    end
    check("annul_no_ready", 64'(saw_ready), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 1'b0);

    // Asynchronous reset mid-division
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hDEADBEEF;
    bus.opdata2_i    = 32'd5;
    bus.start_i      = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(bus.busy_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy_o), 64'd0);
    check("async_rst_ready", 64'(bus.ready_o), 64'd0);
    check("async_rst_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div(1'b1, 32'hFFFFFF00, 32'd16, 1'b0);

    // Random divisions
    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = a + 32'($urandom_range(1, 1000));
        3: b = {$urandom_range(0, 1) == 1 ? 16'hFFFF : 16'h0000, 16'($urandom)};
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
